window_3x3_linebuf: RTL

- Upstream neighbour of the 3x3 convolution kernels in the 256x256 pipeline.
- Accepts a raster-order pixel stream: one pixel per in_valid cycle, row-major, top-left first.
- Uses two line buffers plus a 3x3 register window to present nine neighbourhood taps (p0..p8) to a combinational kernel.
- Emits a window only when the 3x3 neighbourhood lies entirely inside the image, so each frame yields (IMG_W-2)*(IMG_H-2) windows.

---
 rtl/window_3x3_linebuf.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/window_3x3_linebuf.sv
// rtl/window_3x3_linebuf.sv - raster-stream 3x3 neighbourhood window generator
//
// Purpose: turns a row-major pixel stream into 3x3 windows for a downstream
// combinational kernel. Two line buffers hold the previous two rows; a 3x3
// register window shifts left one column per accepted pixel.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid             in_pixel accepted this cycle
//   in_sof               with in_valid: accepted pixel is (0,0) of a new frame
//   in_pixel[PIX_W]      input pixel
//   p0..p8[PIX_W]        window taps, row-major; p4 is the centre
//   out_valid            taps/coordinates form a fully in-image window
//   out_x, out_y[CW]     centre coordinates of the window
//   frame_done           one-cycle pulse after the last pixel of a frame
module window_3x3_linebuf #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 17,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    output logic             out_valid,
    output logic [CW-1:0]    out_x,
    output logic [CW-1:0]    out_y,
    output logic             frame_done
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    // lb0 holds row y-1, lb1 holds row y-2; deliberately not reset.
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];

    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] win_d [9];
    logic [CW-1:0]    x_q, x_d, y_q, y_d;
    logic [CW-1:0]    out_x_q, out_x_d, out_y_q, out_y_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;

    logic [CW-1:0]    cur_x, cur_y;
    logic [AW-1:0]    addr;
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic             last_col, last_row;

    always_comb begin
        // in_sof forces the accepted pixel to (0,0), which resynchronises
        // a frame that was interrupted part-way.
        cur_x    = in_sof ? '0 : x_q;
        cur_y    = in_sof ? '0 : y_q;
        addr     = cur_x[AW-1:0];
        lb0_rd   = lb0[addr];
        lb1_rd   = lb1[addr];
        last_col = (cur_x == CW'(IMG_W - 1));
        last_row = (cur_y == CW'(IMG_H - 1));

        x_d          = x_q;
        y_d          = y_q;
        win_d        = win_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (in_valid) begin
            x_d = last_col ? '0 : cur_x + CW'(1);
            y_d = last_col ? (last_row ? '0 : cur_y + CW'(1)) : cur_y;
            for (int r = 0; r < 3; r++) begin
                win_d[r*3]     = win_q[r*3+1];
                win_d[r*3+1]   = win_q[r*3+2];
            end
            win_d[2] = lb1_rd;
            win_d[5] = lb0_rd;
            win_d[8] = in_pixel;
            out_x_d  = cur_x - CW'(1);
            out_y_d  = cur_y - CW'(1);
            // Gating on x>=2 also hides windows straddling a row wrap, and
            // y>=2 hides line-buffer contents left over from older frames.
            out_valid_d  = (cur_x >= CW'(2)) && (cur_y >= CW'(2));
            frame_done_d = last_col && last_row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            win_q        <= '{default: '0};
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            win_q        <= win_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Reads above see the old contents, so lb1 receives the row that lb0
    // held before this pixel overwrites it.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb1[addr] <= lb0_rd;
            lb0[addr] <= in_pixel;
        end
    end

    assign p0         = win_q[0];
    assign p1         = win_q[1];
    assign p2         = win_q[2];
    assign p3         = win_q[3];
    assign p4         = win_q[4];
    assign p5         = win_q[5];
    assign p6         = win_q[6];
    assign p7         = win_q[7];
    assign p8         = win_q[8];
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign frame_done = frame_done_q;

endmodule
